four_ll_adder: RTL and testbench
================================

// Module: four_ll_adder
// PURPOSE
//   4-bit ripple-carry adder built from four 1-bit full adders, with carry-in and carry-out.
//   Operands arrive as individual bit ports; bit 0 is the LSB.
//   Sum and carry-out are registered, so the block drops into clocked datapaths.
//   Used as the adder half of the sumador-restador (adder/subtractor) datapath.
// PARAMETERS
//   none; width is fixed at 4 bits (see STRUCTURE).
// PORTS
//   clk      in   1  single clock, rising-edge active
//   rst_n    in   1  asynchronous, active-low reset
//   in_a0    in   1  operand A bit 0 (LSB)
//   in_a1    in   1  operand A bit 1
//   in_a2    in   1  operand A bit 2
//   in_a3    in   1  operand A bit 3 (MSB)
//   in_b0    in   1  operand B bit 0 (LSB)
//   in_b1    in   1  operand B bit 1
//   in_b2    in   1  operand B bit 2
//   in_b3    in   1  operand B bit 3 (MSB)
//   in_ca0   in   1  carry-in to bit 0
//   out_s0   out  1  sum bit 0 (LSB), registered
//   out_s1   out  1  sum bit 1, registered
//   out_s2   out  1  sum bit 2, registered
//   out_s3   out  1  sum bit 3 (MSB), registered
//   out_ca   out  1  carry-out of bit 3, registered
// BEHAVIOUR
//   - A = {in_a3,in_a2,in_a1,in_a0} and B = {in_b3,..,in_b0} are unsigned 4-bit values.
//   - Result: {out_ca,out_s3,out_s2,out_s1,out_s0} = A + B + in_ca0, computed as 5 bits.
//   - No overflow flag and no saturation; values above 15 are carried out on out_ca.
//   - Ripple chain: c0 = in_ca0; s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | c_i&(a_i^b_i).
//   - out_ca = c4.
//   - Inputs are combinational into the chain; the 5 result bits are captured on every rising clk.
//   - Latency: 1 cycle. Inputs stable before edge k appear on the outputs after edge k.
//   - No enable and no handshake; throughput is one result per cycle.
//   - Reset:
//       * rst_n low clears all five outputs to 0 immediately, without waiting for a clock edge.
//       * Reset asserted mid-operation discards any pending result.
//       * After rst_n deasserts, the first rising edge loads the current inputs.
//   - X or Z on any input is not handled; callers must drive every input.
//   - The result wraps modulo 32: 15+15+1 = 31 gives all outputs 1.
// STRUCTURE
//   - Shared package: localparam ADDER_W = 4, plus a 5-bit result typedef {carry, sum[3:0]}.
//   - Sub-module full_adder (a, b, cin -> s, cout), purely combinational.
//   - Instantiate full_adder four times, chained cout -> cin.
//   - One output register stage with async clear on rst_n.
// TESTING
//   - Reset: rst_n=0 with A=0xF, B=0xF, ca0=1 -> all outputs 0, with or without clk edges.
//   - Zero: A=0, B=0, ca0=0 -> after 1 edge s=0000, out_ca=0.
//   - Carry-in only: A=0, B=0, ca0=1 -> s=0001, out_ca=0.
//   - Full ripple: A=0xF, B=0x0, ca0=1 -> s=0000, out_ca=1.
//   - Maximum: A=0xF, B=0xF, ca0=1 -> s=1111, out_ca=1; A=0x5, B=0xA, ca0=0 -> s=1111, out_ca=0.
//   - Exhaustive: sweep all 512 {A,B,ca0} combos, one per cycle.
//       * Check each result one cycle later against the 5-bit reference sum.
//       * Assert rst_n low mid-sweep -> outputs 0 at once; checking resumes one edge after release.

Source files
------------

// File: rtl/four_ll_adder_pkg.sv
// ---------------------------------------------------------------------------
// four_ll_adder_pkg
//   Shared definitions for the 4-bit registered ripple-carry adder.
//   ADDER_W  : operand width in bits (fixed at 4).
//   result_t : 5-bit packed result {carry, sum[3:0]}.
// ---------------------------------------------------------------------------
package four_ll_adder_pkg;

  localparam int ADDER_W = 4;

  typedef struct packed {
    logic               carry;
    logic [ADDER_W-1:0] sum;
  } result_t;

endpackage : four_ll_adder_pkg

// File: rtl/four_ll_adder_if.sv
// ---------------------------------------------------------------------------
// four_ll_adder_if
//   Bundles the bit-level operand, carry-in and result signals of the adder.
//   master : drives in_a*/in_b*/in_ca0, observes out_s*/out_ca (the user side).
//   slave  : receives the operands, drives the registered result (the adder).
// ---------------------------------------------------------------------------
interface four_ll_adder_if;

  logic in_a0;
  logic in_a1;
  logic in_a2;
  logic in_a3;
  logic in_b0;
  logic in_b1;
  logic in_b2;
  logic in_b3;
  logic in_ca0;
  logic out_s0;
  logic out_s1;
  logic out_s2;
  logic out_s3;
  logic out_ca;

  modport master (
    output in_a0, in_a1, in_a2, in_a3,
    output in_b0, in_b1, in_b2, in_b3,
    output in_ca0,
    input  out_s0, out_s1, out_s2, out_s3,
    input  out_ca
  );

  modport slave (
    input  in_a0, in_a1, in_a2, in_a3,
    input  in_b0, in_b1, in_b2, in_b3,
    input  in_ca0,
    output out_s0, out_s1, out_s2, out_s3,
    output out_ca
  );

endinterface : four_ll_adder_if

// File: rtl/four_ll_adder_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   Purely combinational 1-bit full adder.
//   i_a, i_b : operand bits
//   i_cin    : carry in
//   o_s      : sum bit
//   o_cout   : carry out (generate, or propagate of the incoming carry)
// ---------------------------------------------------------------------------
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_p;

  assign w_p    = i_a ^ i_b;
  assign o_s    = w_p ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule : full_adder

// File: rtl/four_ll_adder.sv
// ---------------------------------------------------------------------------
// four_ll_adder
//   4-bit ripple-carry adder with carry-in/carry-out and a single output
//   register stage. The result {out_ca, out_s3..out_s0} = A + B + in_ca0,
//   taken modulo 32, appears one rising clk edge after the inputs settle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear of all five result bits
//   bus   : slave side of four_ll_adder_if (operand bits in, result bits out)
// ---------------------------------------------------------------------------
module four_ll_adder
  import four_ll_adder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  four_ll_adder_if.slave    bus
);

  logic [ADDER_W-1:0] w_a;
  logic [ADDER_W-1:0] w_b;
  logic [ADDER_W-1:0] w_s;
  logic [ADDER_W:0]   w_c;
  result_t            w_next;
  result_t            r_result;

  assign w_a    = {bus.in_a3, bus.in_a2, bus.in_a1, bus.in_a0};
  assign w_b    = {bus.in_b3, bus.in_b2, bus.in_b1, bus.in_b0};
  assign w_c[0] = bus.in_ca0;

  // Carry ripples from bit 0 upward; each stage's cout feeds the next cin.
  for (genvar gi = 0; gi < ADDER_W; gi++) begin : g_fa
    full_adder u_fa (
      .i_a    (w_a[gi]),
      .i_b    (w_b[gi]),
      .i_cin  (w_c[gi]),
      .o_s    (w_s[gi]),
      .o_cout (w_c[gi+1])
    );
  end

  assign w_next = {w_c[ADDER_W], w_s};

  // Result register: cleared immediately on reset, otherwise loads every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '{carry: 1'b0, sum: 4'b0000};
    end else begin
      r_result <= w_next;
    end
  end

  assign bus.out_s0 = r_result.sum[0];
  assign bus.out_s1 = r_result.sum[1];
  assign bus.out_s2 = r_result.sum[2];
  assign bus.out_s3 = r_result.sum[3];
  assign bus.out_ca = r_result.carry;

endmodule : four_ll_adder

// File: tb/tb_four_ll_adder.sv
// ---------------------------------------------------------------------------
// tb_four_ll_adder
//   Self-checking bench for four_ll_adder: reset behaviour, a table of
//   hand-computed directed vectors, an exhaustive sweep of all 512 operand
//   combinations and an asynchronous reset asserted in the middle of it.
// ---------------------------------------------------------------------------
module tb_four_ll_adder;

  logic clk;
  logic rst_n;

  four_ll_adder_if bus_if ();

  four_ll_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [4:0] exp;   // {carry, sum[3:0]}
  } vec_t;

  vec_t vecs [9];

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci);
    bus_if.in_a0  = a[0];
    bus_if.in_a1  = a[1];
    bus_if.in_a2  = a[2];
    bus_if.in_a3  = a[3];
    bus_if.in_b0  = b[0];
    bus_if.in_b1  = b[1];
    bus_if.in_b2  = b[2];
    bus_if.in_b3  = b[3];
    bus_if.in_ca0 = ci;
  endtask

  function automatic logic [4:0] result();
    return {bus_if.out_ca, bus_if.out_s3, bus_if.out_s2, bus_if.out_s1, bus_if.out_s0};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got {ca,s}=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    logic [4:0] prev;
    logic [4:0] model;
    logic [8:0] v;

    vecs[0] = '{"zero",         4'h0, 4'h0, 1'b0, 5'b0_0000};
    vecs[1] = '{"carry_in",     4'h0, 4'h0, 1'b1, 5'b0_0001};
    vecs[2] = '{"full_ripple",  4'hF, 4'h0, 1'b1, 5'b1_0000};
    vecs[3] = '{"maximum",      4'hF, 4'hF, 1'b1, 5'b1_1111};
    vecs[4] = '{"alt_bits",     4'h5, 4'hA, 1'b0, 5'b0_1111};
    vecs[5] = '{"seven_nine",   4'h7, 4'h9, 1'b0, 5'b1_0000};
    vecs[6] = '{"three_four_c", 4'h3, 4'h4, 1'b1, 5'b0_1000};
    vecs[7] = '{"msb_pair",     4'h8, 4'h8, 1'b0, 5'b1_0000};
    vecs[8] = '{"alt_bits_c",   4'hA, 4'h5, 1'b1, 5'b1_0000};

    // Reset held with all-ones inputs: outputs clear before and across edges.
    rst_n = 1'b0;
    drive(4'hF, 4'hF, 1'b1);
    #3;
    check("reset_no_edge", result(), 5'b0_0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_with_edges", result(), 5'b0_0000);

    // Release between edges; the first rising edge loads the current inputs.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_after_release", result(), 5'b1_1111);
    prev = 5'b1_1111;

    // Directed table: output must hold until the edge, then show the new sum.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].ci);
      #1;
      check({vecs[i].name, "_hold"}, result(), prev);
      @(posedge clk);
      #1;
      check(vecs[i].name, result(), vecs[i].exp);
      prev = vecs[i].exp;
    end

    // Mid-operation reset: a loaded result is discarded without a clock edge.
    @(negedge clk);
    drive(4'hF, 4'hF, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", result(), 5'b0_0000);
    @(negedge clk);
    drive(4'h5, 4'hA, 1'b0);
    rst_n = 1'b1;
    #1;
    check("released_no_edge", result(), 5'b0_0000);
    @(posedge clk);
    #1;
    check("load_after_release", result(), 5'b0_1111);

    // Exhaustive sweep against an arithmetic reference, reset asserted midway.
    for (int i = 0; i < 512; i++) begin
      v = i[8:0];
      model = {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'b0000, v[0]};
      @(negedge clk);
      drive(v[8:5], v[4:1], v[0]);
      @(posedge clk);
      #1;
      check($sformatf("sweep_%0d", i), result(), model);
      if (i == 300) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("sweep_async_rst", result(), 5'b0_0000);
        @(posedge clk);
        #1;
        check("sweep_rst_held", result(), 5'b0_0000);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_four_ll_adder
